// File: rtl/led_pkg.sv
// led_pkg
//   Shared definitions for the LED fade/PWM stage: FSM state encoding and
//   default sizing constants used by led_fade_pwm and led_pwm_gen.
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF  = 2'd0,
      LED_RISE = 2'd1,
      LED_ON   = 2'd2,
      LED_FALL = 2'd3
   } led_state_t;

   localparam int LED_PWM_BITS_DEF = 8;
   localparam int LED_STEP_DIV_DEF = 4;

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen
//   Free-running PWM counter and registered comparator.
//   pwm_cnt counts 0..DUTY_MAX-1 (period DUTY_MAX clocks), so a compare value
//   of 0 gives constant low and DUTY_MAX gives constant high.
// Ports
//   clk         in   clock, posedge
//   reset       in   synchronous, active-high
//   clear       in   synchronous soft clear (counter and output to 0)
//   duty_cmp    in   PWM_BITS compare value
//   pwm_out     out  registered PWM output
//   period_end  out  high on the last count of each PWM period
module led_pwm_gen
   import led_pkg::*;
#(
   parameter int PWM_BITS = LED_PWM_BITS_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic [PWM_BITS-1:0] duty_cmp,
   output logic                pwm_out,
   output logic                period_end
);

   // Last count is DUTY_MAX-1 = 2**PWM_BITS-2, giving a DUTY_MAX-clock period.
   localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2**PWM_BITS) - 2);

   logic [PWM_BITS-1:0] pwm_cnt;

   assign period_end = (pwm_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         pwm_cnt <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= (pwm_cnt < duty_cmp);
         pwm_cnt <= period_end ? '0 : pwm_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm
//   Drives an LED pin with PWM that ramps linearly between off and fully on
//   ("breathing") following the 1-bit level from the blink stage.
// Ports
//   clk      in   clock, all logic on posedge
//   reset    in   synchronous, active-high
//   led_in   in   target level (1 = fully on)
//   enable   in   0 = soft clear: OFF, duty 0, PWM output 0
//   pwm_out  out  registered PWM drive
//   duty     out  current linear duty level (PWM_BITS)
//   busy     out  1 while ramping (RISE or FALL)
// Configuration
//   LED_FADE_GAMMA_EN : when defined the PWM compare value is the gamma
//   approximation (duty*(duty+1)) >> PWM_BITS; otherwise it is duty itself.
//   The duty port stays linear in both builds.
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int PWM_BITS = LED_PWM_BITS_DEF,
   parameter int STEP_DIV = LED_STEP_DIV_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                led_in,
   input  logic                enable,
   output logic                pwm_out,
   output logic [PWM_BITS-1:0] duty,
   output logic                busy
);

   localparam logic [PWM_BITS-1:0] DUTY_MAX    = '1;
   localparam logic [PWM_BITS-1:0] DUTY_MAX_M1 = DUTY_MAX - 1'b1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE    = PWM_BITS'(1);
   localparam int                  STEP_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEP_DIV - 1);

   led_state_t          state;
   led_state_t          state_nxt;
   logic                led_q;
   logic [STEP_W-1:0]   step_cnt;
   logic                step;
   logic                period_end;
   logic [PWM_BITS-1:0] duty_cmp;

   function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] d);
      return (d == DUTY_MAX) ? d : d + 1'b1;
   endfunction

   function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] d);
      return (d == '0) ? d : d - 1'b1;
   endfunction

`ifdef LED_FADE_GAMMA_EN
   // d*(d+1) never exceeds (2**P-1)*2**P, so the upper half is the exact
   // result and both endpoints map to themselves.
   function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] d);
      logic [2*PWM_BITS-1:0] prod;
      prod = ({{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d}) + {{PWM_BITS{1'b0}}, d};
      return prod[2*PWM_BITS-1:PWM_BITS];
   endfunction

   assign duty_cmp = gamma_map(duty);
`else
   assign duty_cmp = duty;
`endif

   // Input register: the FSM only ever looks at led_q.
   always_ff @(posedge clk) begin
      if (reset) led_q <= 1'b0;
      else       led_q <= led_in;
   end

   // A duty step lands on the last PWM count, so the new duty takes effect
   // from the start of the next period.
   assign step = period_end && (step_cnt == STEP_LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset || !enable) state <= LED_OFF;
      else                  state <= state_nxt;
   end

   // FSM next state; a reversal request wins over a pending step.
   always_comb begin
      state_nxt = state;
      case (state)
         LED_OFF:  if (led_q) state_nxt = LED_RISE;
         LED_RISE: begin
            if (!led_q)
               state_nxt = LED_FALL;
            else if ((duty == DUTY_MAX) || (step && (duty == DUTY_MAX_M1)))
               state_nxt = LED_ON;
         end
         LED_ON:   if (!led_q) state_nxt = LED_FALL;
         LED_FALL: begin
            if (led_q)
               state_nxt = LED_RISE;
            else if ((duty == '0) || (step && (duty == DUTY_ONE)))
               state_nxt = LED_OFF;
         end
         default:  state_nxt = LED_OFF;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state == LED_RISE) || (state == LED_FALL);
   end

   // Duty level and step divider
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         duty     <= '0;
         step_cnt <= '0;
      end else begin
         case (state)
            LED_OFF: begin
               duty     <= '0;
               step_cnt <= '0;
            end
            LED_ON: begin
               duty     <= DUTY_MAX;
               step_cnt <= '0;
            end
            LED_RISE: begin
               if (!led_q) begin
                  step_cnt <= '0;
               end else begin
                  if (period_end) step_cnt <= step ? '0 : step_cnt + 1'b1;
                  if (step)       duty     <= sat_inc(duty);
               end
            end
            LED_FALL: begin
               if (led_q) begin
                  step_cnt <= '0;
               end else begin
                  if (period_end) step_cnt <= step ? '0 : step_cnt + 1'b1;
                  if (step)       duty     <= sat_dec(duty);
               end
            end
            default: begin
               duty     <= '0;
               step_cnt <= '0;
            end
         endcase
      end
   end

   led_pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk        (clk),
      .reset      (reset),
      .clear      (!enable),
      .duty_cmp   (duty_cmp),
      .pwm_out    (pwm_out),
      .period_end (period_end)
   );

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm
//   Self-checking bench for led_fade_pwm with PWM_BITS=4 (DUTY_MAX=15,
//   15-clock period) and STEP_DIV=2 (one duty step every 30 clocks).
//   A behavioural model tracks the expected outputs every clock; directed
//   table records, hand-written corner sequences and a randomized run drive it.
module tb_led_fade_pwm;

   localparam int PB   = 4;
   localparam int SD   = 2;
   localparam int DMAX = 15;

   logic          clk;
   logic          reset;
   logic          led_in;
   logic          enable;
   logic          pwm_out;
   logic [PB-1:0] duty;
   logic          busy;

   int n_asserts = 0;
   int n_fail    = 0;

   led_fade_pwm #(
      .PWM_BITS (PB),
      .STEP_DIV (SD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .led_in  (led_in),
      .enable  (enable),
      .pwm_out (pwm_out),
      .duty    (duty),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 off, 1 rising, 2 fully on, 3 falling
   int m_mode  = 0;
   int m_duty  = 0;
   int m_pos   = 0;   // clocks into the current PWM period
   int m_nper  = 0;   // completed periods since the current ramp segment began
   bit m_ledq  = 0;
   bit m_pwm   = 0;

   function automatic int cmp_of(input int d);
`ifdef LED_FADE_GAMMA_EN
      return (d * (d + 1)) / 16;
`else
      return d;
`endif
   endfunction

   task automatic model_step();
      bit lq;
      bit pend;
      lq = m_ledq;
      if (reset) begin
         m_mode = 0; m_duty = 0; m_pos = 0; m_nper = 0; m_ledq = 0; m_pwm = 0;
      end else begin
         m_ledq = led_in;
         if (!enable) begin
            m_mode = 0; m_duty = 0; m_pos = 0; m_nper = 0; m_pwm = 0;
         end else begin
            m_pwm = (m_pos < cmp_of(m_duty));
            pend  = (m_pos == DMAX - 1);
            m_pos = (m_pos + 1) % DMAX;
            case (m_mode)
               0: begin
                  m_duty = 0; m_nper = 0;
                  if (lq) m_mode = 1;
               end
               2: begin
                  m_duty = DMAX; m_nper = 0;
                  if (!lq) m_mode = 3;
               end
               1: begin
                  if (!lq) begin
                     m_mode = 3; m_nper = 0;
                  end else if (m_duty == DMAX) begin
                     m_mode = 2;
                  end else if (pend) begin
                     m_nper++;
                     if (m_nper == SD) begin
                        m_nper = 0;
                        m_duty++;
                        if (m_duty == DMAX) m_mode = 2;
                     end
                  end
               end
               default: begin
                  if (lq) begin
                     m_mode = 1; m_nper = 0;
                  end else if (m_duty == 0) begin
                     m_mode = 0;
                  end else if (pend) begin
                     m_nper++;
                     if (m_nper == SD) begin
                        m_nper = 0;
                        m_duty--;
                        if (m_duty == 0) m_mode = 0;
                     end
                  end
               end
            endcase
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_asserts++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: model advances on the same edge, outputs sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("model_duty", int'(duty), m_duty);
      chk("model_busy", int'(busy), int'(m_mode == 1 || m_mode == 3));
      chk("model_pwm",  int'(pwm_out), int'(m_pwm));
   endtask

   task automatic wait_duty(input int target, input int bound, input string name);
      int n;
      n = 0;
      while (int'(duty) != target && n < bound) begin
         tick();
         n++;
      end
      chk(name, int'(duty), target);
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n;
      n = 0;
      while ((duty != '0 || busy) && n < bound) begin
         tick();
         n++;
      end
      chk(name, int'(busy), 0);
   endtask

   // Counts pwm_out highs over one full period right after a duty change.
   task automatic measure(input int d, input string name);
      int highs;
      int first;
      highs = 0;
      first = 0;
      for (int k = 0; k < DMAX; k++) begin
         tick();
         if (k == 0) first = int'(pwm_out);
         if (pwm_out) highs++;
      end
      chk({name, "_highs"}, highs, cmp_of(d));
      chk({name, "_first"}, first, int'(cmp_of(d) > 0));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit    rst;
      bit    en;
      bit    led;
      int    ncyc;
      int    exp_duty;
      bit    exp_busy;
      bit    exp_pwm;
      string name;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int maxd;
      bit saw6;
      int n;

      vecs[0] = '{1'b1, 1'b1, 1'b0,    3,  0, 1'b0, 1'b0, "reset_state"};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1000,  0, 1'b0, 1'b0, "idle_1000"};
      vecs[2] = '{1'b0, 1'b1, 1'b1,    1,  0, 1'b0, 1'b0, "led_q_only"};
      vecs[3] = '{1'b0, 1'b1, 1'b1,    1,  0, 1'b1, 1'b0, "busy_after_2"};
      vecs[4] = '{1'b0, 1'b1, 1'b1,  600, DMAX, 1'b0, 1'b1, "reached_on"};
      vecs[5] = '{1'b0, 1'b1, 1'b0,    2, DMAX, 1'b1, 1'b1, "fall_start"};
      vecs[6] = '{1'b0, 1'b1, 1'b0,  600,  0, 1'b0, 1'b0, "reached_off"};
      vecs[7] = '{1'b0, 1'b0, 1'b1,   50,  0, 1'b0, 1'b0, "disabled_hold"};
      vecs[8] = '{1'b0, 1'b1, 1'b1,    2,  0, 1'b1, 1'b0, "restart_from_off"};
      vecs[9] = '{1'b1, 1'b1, 1'b1,    1,  0, 1'b0, 1'b0, "reset_mid_rise"};

      reset  = 1'b1;
      enable = 1'b1;
      led_in = 1'b0;

      for (int i = 0; i < 10; i++) begin
         reset  = vecs[i].rst;
         enable = vecs[i].en;
         led_in = vecs[i].led;
         for (int c = 0; c < vecs[i].ncyc; c++) tick();
         chk({vecs[i].name, "_duty"}, int'(duty), vecs[i].exp_duty);
         chk({vecs[i].name, "_busy"}, int'(busy), int'(vecs[i].exp_busy));
         chk({vecs[i].name, "_pwm"},  int'(pwm_out), int'(vecs[i].exp_pwm));
      end

      // Duty waveform at fixed levels 5, 8 and full on.
      reset = 1'b0; enable = 1'b1; led_in = 1'b1;
      wait_duty(5, 400, "reach_d5");
      measure(5, "pwm_d5");
      wait_duty(8, 200, "reach_d8");
      measure(8, "pwm_d8");
      wait_duty(DMAX, 400, "reach_d15");
      measure(DMAX, "pwm_d15");

      // Reversal mid-rise at duty 7.
      led_in = 1'b0;
      wait_idle(600, "fall_to_off");
      led_in = 1'b1;
      wait_duty(7, 400, "reach_d7");
      led_in = 1'b0;
      maxd = 0;
      saw6 = 1'b0;
      n = 0;
      while ((duty != '0 || busy) && n < 400) begin
         tick();
         if (int'(duty) > maxd) maxd = int'(duty);
         if (duty == 4'd6) saw6 = 1'b1;
         n++;
      end
      chk("rev_max_duty", maxd, 7);
      chk("rev_saw_6", int'(saw6), 1);
      chk("rev_end_duty", int'(duty), 0);
      chk("rev_end_busy", int'(busy), 0);

      // Soft clear mid-rise at duty 9.
      led_in = 1'b1;
      wait_duty(9, 400, "reach_d9");
      enable = 1'b0;
      tick();
      chk("en0_duty", int'(duty), 0);
      chk("en0_pwm",  int'(pwm_out), 0);
      chk("en0_busy", int'(busy), 0);

      // Reset mid-fall at duty 10.
      enable = 1'b1;
      wait_duty(DMAX, 600, "reach_on_again");
      led_in = 1'b0;
      wait_duty(10, 400, "reach_d10_fall");
      chk("fall_busy", int'(busy), 1);
      reset = 1'b1;
      tick();
      chk("rst_fall_duty", int'(duty), 0);
      chk("rst_fall_busy", int'(busy), 0);
      chk("rst_fall_pwm",  int'(pwm_out), 0);
      reset = 1'b0;

      // Randomized run, checked every clock against the model.
      begin
         int en_cnt;
         en_cnt = 0;
         for (int i = 0; i < 5000; i++) begin
            reset = ($urandom_range(0, 699) == 0);
            if (en_cnt > 0) en_cnt--;
            else if ($urandom_range(0, 399) == 0) en_cnt = $urandom_range(1, 20);
            enable = (en_cnt == 0);
            if ($urandom_range(0, 249) == 0) led_in = ~led_in;
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
